// File: rtl/acia_rx_feeder.sv
// acia_rx_feeder: byte FIFO feeding an 8N1 serializer that drives the ACIA rx pin.
// Define ACIA_FEED_GAP_EN to add GAP_BITS idle bit-times after every stop bit.
module acia_rx_feeder #(
  parameter int FIFO_AW    = 4,
  parameter int BIT_CYCLES = 4096,
  parameter int GAP_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rate_sel,
  input  logic [7:0]       din,
  input  logic             din_strobe,
  input  logic             flush,
  output logic             rx,
  output logic             busy,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BIT_CYCLES);

  localparam logic [CW-1:0] LAST_SLOW = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_FAST = CW'((BIT_CYCLES >> 2) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
`ifdef ACIA_FEED_GAP_EN
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam int         GW      = $clog2(GAP_BITS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  if (GAP_BITS < 1) begin : g_bad_gap
    $error("GAP_BITS must be at least 1 when the gap is enabled");
  end
`else
  if (GAP_BITS < 0) begin : g_bad_gap
    $error("GAP_BITS must be non-negative");
  end
`endif

  if (BIT_CYCLES < 8) begin : g_bad_rate
    $error("BIT_CYCLES must be at least 8");
  end

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push;
  logic               pop;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          rate_q;
  logic          bit_end;
  logic          frame_end;
`ifdef ACIA_FEED_GAP_EN
  logic [GW-1:0] gap_idx;
`endif

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = fifo_level[FIFO_AW];
  assign busy       = (state != S_IDLE);

  // a full FIFO rejects pushes even when a pop frees a slot this cycle
  assign push = din_strobe && !fifo_full;

  assign bit_end = rate_q ? (cnt == LAST_FAST) : (cnt == LAST_SLOW);

`ifdef ACIA_FEED_GAP_EN
  assign frame_end = bit_end && (state == S_GAP) && (gap_idx == GAP_LAST);
`else
  assign frame_end = bit_end && (state == S_STOP);
`endif

  assign pop = !fifo_empty && ((state == S_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (reset_n && !flush && push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (din_strobe && fifo_full) begin
        overflow <= 1'b1;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state  <= S_IDLE;
      rx     <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      rate_q <= 1'b0;
`ifdef ACIA_FEED_GAP_EN
      gap_idx <= '0;
`endif
    end else begin
      if (state == S_IDLE || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          rx <= 1'b1;
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            idx   <= '0;
            rx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx == 3'd7) begin
              state <= S_STOP;
              rx    <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              rx    <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
`ifdef ACIA_FEED_GAP_EN
            state   <= S_GAP;
            gap_idx <= '0;
`else
            state <= S_IDLE;
`endif
          end
        end
`ifdef ACIA_FEED_GAP_EN
        S_GAP: begin
          if (bit_end) begin
            if (gap_idx == GAP_LAST) begin
              state <= S_IDLE;
            end else begin
              gap_idx <= gap_idx + 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          rx    <= 1'b1;
        end
      endcase

      // a pop overrides the IDLE fall-through so frames run back to back
      if (pop) begin
        state <= S_START;
        rx    <= 1'b0;
        shreg <= mem[rd_ptr];
        if (state == S_IDLE) begin
          rate_q <= rate_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_acia_rx_feeder.sv
// tb_acia_rx_feeder: directed stimulus with a byte scoreboard and a serial-line monitor.
// Build with ACIA_FEED_GAP_EN to check the gapped frame pitch.
module tb_acia_rx_feeder;

  localparam int P_SLOW = 16;
  localparam int P_FAST = 4;
`ifdef ACIA_FEED_GAP_EN
  localparam int PITCH = 12;
`else
  localparam int PITCH = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rate_sel = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_strobe = 1'b0;
  logic       flush = 1'b0;
  logic       rx;
  logic       busy;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_level;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] sbq[$];
  int         starts[$];
  int         mon_p = P_SLOW;
  bit         mact = 1'b0;
  int         mcnt = 0;
  bit         mshape = 1'b1;
  logic [7:0] mbyte = 8'h00;
  logic [7:0] mexp = 8'h00;

  acia_rx_feeder #(
    .FIFO_AW   (4),
    .BIT_CYCLES(P_SLOW),
    .GAP_BITS  (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rate_sel  (rate_sel),
    .din       (din),
    .din_strobe(din_strobe),
    .flush     (flush),
    .rx        (rx),
    .busy      (busy),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    din = b;
    din_strobe = 1'b1;
    if (acc) sbq.push_back(b);
    tick(1);
    din_strobe = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx"}, 32'(rx), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_empty"}, 32'(fifo_empty), 1);
    check({tag, "_full"}, 32'(fifo_full), 0);
    check({tag, "_level"}, 32'(fifo_level), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sbq.size() != 0 || mact || busy) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(sbq.size()), 0);
    check({name, "_idle"}, 32'(busy), 0);
  endtask

  // serial monitor: checks every cycle of each frame against the queue head
  always @(negedge clk) begin
    if (!reset_n || flush) begin
      mact = 1'b0;
    end else begin
      if (!mact && rx === 1'b0) begin
        mact = 1'b1;
        mcnt = 0;
        mshape = 1'b1;
        mbyte = 8'h00;
        starts.push_back(cyc);
        check("frame_expected", 32'(sbq.size() != 0), 1);
        mexp = (sbq.size() != 0) ? sbq[0] : 8'h00;
      end
      if (mact) begin
        int k;
        logic eb;
        k = mcnt / mon_p;
        eb = (k == 0) ? 1'b0 : (k >= 9) ? 1'b1 : mexp[k-1];
        if (rx !== eb || busy !== 1'b1) mshape = 1'b0;
        if (k >= 1 && k <= 8 && (mcnt % mon_p) == mon_p / 2) mbyte[k-1] = rx;
        if (mcnt == 10 * mon_p - 1) begin
          check("frame", {23'd0, mshape, mbyte}, {23'd0, 1'b1, mexp});
          if (sbq.size() != 0) void'(sbq.pop_front());
          mact = 1'b0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;

    tick(3);
    check_reset("rst");
    reset_n = 1'b1;
    tick(2);

    // single slow frame
    rate_sel = 1'b0;
    mon_p = P_SLOW;
    push(8'hA5, 1'b1);
    check("t1_level", 32'(fifo_level), 1);
    check("t1_empty", 32'(fifo_empty), 0);
    tick(1);
    check("t1_rx_start", 32'(rx), 0);
    check("t1_level_pop", 32'(fifo_level), 0);
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick(1);
    end
    check("t1_busy_len", 32'(n), 32'(PITCH * P_SLOW));
    wait_drain("t1_drain", 400);

    // back-to-back fast frames
    rate_sel = 1'b1;
    mon_p = P_FAST;
    base = starts.size();
    push(8'h01, 1'b1);
    push(8'hFF, 1'b1);
    n = 0;
    while (starts.size() < base + 2 && n < 300) begin
      n++;
      tick(1);
    end
    check("t2_count", 32'(starts.size() - base), 2);
    if (starts.size() >= base + 2)
      check("t2_pitch", 32'(starts[base+1] - starts[base]), 32'(PITCH * P_FAST));
    wait_drain("t2_drain", 200);
    rate_sel = 1'b0;
    mon_p = P_SLOW;

    // overflow while a frame holds the serializer
    push(8'h11, 1'b1);
    for (int i = 0; i < 17; i++) push(8'(8'h20 + i), i < 16);
    check("t3_full", 32'(fifo_full), 1);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_level", 32'(fifo_level), 16);
    wait_drain("t3_drain", 17 * PITCH * P_SLOW + 200);
    check("t3_ovf_sticky", 32'(overflow), 1);
    check("t3_empty", 32'(fifo_empty), 1);

    // flush in the middle of data bit 3, with a discarded push
    push(8'hC3, 1'b1);
    tick(70);
    flush = 1'b1;
    din = 8'h77;
    din_strobe = 1'b1;
    tick(1);
    flush = 1'b0;
    din_strobe = 1'b0;
    sbq.delete();
    check("t4_rx", 32'(rx), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_level", 32'(fifo_level), 0);
    check("t4_ovf", 32'(overflow), 0);
    base = starts.size();
    tick(400);
    check("t4_no_frame", 32'(starts.size() - base), 0);
    check("t4_level_late", 32'(fifo_level), 0);

    // reset mid frame with bytes queued
    push(8'h61, 1'b1);
    push(8'h62, 1'b1);
    push(8'h63, 1'b1);
    push(8'h64, 1'b1);
    tick(50);
    reset_n = 1'b0;
    tick(1);
    sbq.delete();
    check_reset("t5");
    reset_n = 1'b1;
    base = starts.size();
    tick(400);
    check("t5_no_frame", 32'(starts.size() - base), 0);
    check("t5_rx", 32'(rx), 1);

    // push and pop together at level 15
    push(8'h50, 1'b1);
    for (int i = 0; i < 15; i++) push(8'(8'h80 + i), 1'b1);
    check("t6_level_pre", 32'(fifo_level), 15);
    tick(PITCH * P_SLOW - 15);
    check("t6_level_edge", 32'(fifo_level), 15);
    push(8'h9F, 1'b1);
    check("t6_level_after", 32'(fifo_level), 15);
    check("t6_ovf", 32'(overflow), 0);
    wait_drain("t6_drain", 17 * PITCH * P_SLOW + 200);
    check("t6_empty", 32'(fifo_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
